// File: rtl/subcode_rx_tx.sv
// Subcode channel capture with CRC-16 check and 8N1 UART block transmitter.
// One selectable subcode bit is captured per frame strobe; an S0 edge closes the block,
// which is checked, published on qBits and optionally serialised MSB byte first.
module subcode_rx_tx #(
    parameter int unsigned LISTEN_BIT = 6,
    parameter int unsigned BLOCK_BITS = 96,
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned TX_MODE    = 0
) (
    input  logic                  CLK50MHZ,
    input  logic                  rst,
    input  logic                  frameLatch,
    input  logic [7:0]            frameWord,
    input  logic                  S0,
    input  logic                  S1,
    output logic                  TxO,
    output logic [BLOCK_BITS-1:0] qBits,
    output logic                  blockValid,
    output logic                  crcOk,
    output logic                  lenErr,
    output logic                  txBusy,
    output logic [7:0]            overrunCnt
);
    localparam int unsigned CntW   = $clog2(BLOCK_BITS + 2);
    localparam int unsigned NBytes = BLOCK_BITS / 8;
    localparam int unsigned ByteW  = $clog2(NBytes + 1);
    localparam int unsigned BaudW  = $clog2(BAUD_DIV + 1);

    localparam logic [CntW-1:0]  CntMax  = CntW'(BLOCK_BITS + 1);
    localparam logic [CntW-1:0]  CntFull = CntW'(BLOCK_BITS);
    localparam logic [CntW-1:0]  CntCrc  = CntW'(BLOCK_BITS - 16);
    localparam logic [BaudW-1:0] BaudEnd = BaudW'(BAUD_DIV - 1);
    localparam logic [ByteW-1:0] ByteNum = ByteW'(NBytes);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    // Synchroniser and edge-register state
    logic fl_meta_q, fl_meta_d, fl_sync_q, fl_sync_d, fl_dly_q, fl_dly_d;
    logic s0_meta_q, s0_meta_d, s0_sync_q, s0_sync_d, s0_dly_q, s0_dly_d;
    logic s1_meta_q, s1_meta_d, s1_sync_q, s1_sync_d;
    logic fl_edge, s0_edge;

    // Capture state
    logic [BLOCK_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]           crc_q, crc_d;
    logic [BLOCK_BITS-1:0] q_bits_q, q_bits_d;
    logic                  crc_ok_q, crc_ok_d;
    logic                  len_err_q, len_err_d;
    logic                  block_valid_q, block_valid_d;
    logic                  len_err_nxt;
    logic                  cap_bit;

    // Transmit state
    tx_state_e             state_q, state_d;
    logic [BaudW-1:0]      baud_q, baud_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [ByteW-1:0]      byte_left_q, byte_left_d;
    logic [BLOCK_BITS-1:0] tx_buf_q, tx_buf_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  txo_q, txo_d;
    logic [7:0]            ovr_q, ovr_d;
    logic                  qualify, tx_start, baud_end;

    // Only one frameWord bit is meaningful; the rest are deliberately dropped
    logic unused_fw;
    assign unused_fw = ^frameWord;
    assign cap_bit   = frameWord[LISTEN_BIT];

    // Two-stage synchronisers plus one delay stage for rising-edge detection
    always_comb begin
        fl_meta_d = frameLatch;
        fl_sync_d = fl_meta_q;
        fl_dly_d  = fl_sync_q;
        s0_meta_d = S0;
        s0_sync_d = s0_meta_q;
        s0_dly_d  = s0_sync_q;
        s1_meta_d = S1;
        s1_sync_d = s1_meta_q;
        fl_edge   = fl_sync_q & ~fl_dly_q;
        s0_edge   = s0_sync_q & ~s0_dly_q;
    end

    // Bit capture, running CRC and block close-out; a block end beats a same-cycle frame
    always_comb begin
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        crc_d         = crc_q;
        q_bits_d      = q_bits_q;
        crc_ok_d      = crc_ok_q;
        len_err_d     = len_err_q;
        block_valid_d = 1'b0;
        len_err_nxt   = (bit_cnt_q != CntFull);
        if (s0_edge) begin
            q_bits_d      = shift_q;
            len_err_d     = len_err_nxt;
            crc_ok_d      = !len_err_nxt && (shift_q[15:0] == ~crc_q);
            block_valid_d = 1'b1;
            shift_d       = '0;
            bit_cnt_d     = '0;
            crc_d         = '0;
        end else if (fl_edge && !s0_sync_q && !s1_sync_q) begin
            shift_d = {shift_q[BLOCK_BITS-2:0], cap_bit};
            if (bit_cnt_q != CntMax) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            // Trailing 16 bits carry the inverted CRC and are not folded in
            if (bit_cnt_q < CntCrc) begin
                crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ cap_bit) ? 16'h1021 : 16'h0000);
            end
        end
    end

    // Transmit qualification and saturating overrun count
    always_comb begin
        qualify  = !len_err_q && ((TX_MODE == 0) || crc_ok_q);
        tx_start = block_valid_q && qualify && (state_q == StIdle);
        ovr_d    = ovr_q;
        if (block_valid_q && qualify && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    // UART FSM: bytes back to back, start/8 data LSB first/stop, each bit BAUD_DIV clocks
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_idx_d   = bit_idx_q;
        byte_left_d = byte_left_q;
        tx_buf_d    = tx_buf_q;
        tx_byte_d   = tx_byte_q;
        baud_end    = (baud_q == BaudEnd);
        unique case (state_q)
            StIdle: begin
                if (tx_start) begin
                    state_d     = StStart;
                    baud_d      = '0;
                    tx_buf_d    = q_bits_q;
                    byte_left_d = ByteNum;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d     = StData;
                    baud_d      = '0;
                    bit_idx_d   = '0;
                    tx_byte_d   = tx_buf_q[BLOCK_BITS-1 -: 8];
                    tx_buf_d    = tx_buf_q << 8;
                    byte_left_d = byte_left_q - 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d    = '0;
                    tx_byte_d = tx_byte_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = (byte_left_q != '0) ? StStart : StIdle;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Line level follows the next state so TxO is a clean flop output
        unique case (state_d)
            StStart: txo_d = 1'b0;
            StData:  txo_d = tx_byte_d[0];
            default: txo_d = 1'b1;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK50MHZ) begin
        if (rst) begin
            fl_meta_q     <= 1'b0;
            fl_sync_q     <= 1'b0;
            fl_dly_q      <= 1'b0;
            s0_meta_q     <= 1'b0;
            s0_sync_q     <= 1'b0;
            s0_dly_q      <= 1'b0;
            s1_meta_q     <= 1'b0;
            s1_sync_q     <= 1'b0;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            crc_q         <= '0;
            q_bits_q      <= '0;
            crc_ok_q      <= 1'b0;
            len_err_q     <= 1'b0;
            block_valid_q <= 1'b0;
            state_q       <= StIdle;
            baud_q        <= '0;
            bit_idx_q     <= '0;
            byte_left_q   <= '0;
            tx_buf_q      <= '0;
            tx_byte_q     <= '0;
            txo_q         <= 1'b1;
            ovr_q         <= '0;
        end else begin
            fl_meta_q     <= fl_meta_d;
            fl_sync_q     <= fl_sync_d;
            fl_dly_q      <= fl_dly_d;
            s0_meta_q     <= s0_meta_d;
            s0_sync_q     <= s0_sync_d;
            s0_dly_q      <= s0_dly_d;
            s1_meta_q     <= s1_meta_d;
            s1_sync_q     <= s1_sync_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            crc_q         <= crc_d;
            q_bits_q      <= q_bits_d;
            crc_ok_q      <= crc_ok_d;
            len_err_q     <= len_err_d;
            block_valid_q <= block_valid_d;
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_idx_q     <= bit_idx_d;
            byte_left_q   <= byte_left_d;
            tx_buf_q      <= tx_buf_d;
            tx_byte_q     <= tx_byte_d;
            txo_q         <= txo_d;
            ovr_q         <= ovr_d;
        end
    end

    assign TxO        = txo_q;
    assign qBits      = q_bits_q;
    assign blockValid = block_valid_q;
    assign crcOk      = crc_ok_q;
    assign lenErr     = len_err_q;
    assign txBusy     = (state_q != StIdle);
    assign overrunCnt = ovr_q;

endmodule

// File: tb/tb_subcode_rx_tx.sv
// Bench for subcode_rx_tx: two instances (transmit-all and CRC-good-only) share stimulus.
// Expected blocks and UART bytes are queued when stimulus is driven and popped by monitors.
module tb_subcode_rx_tx;
    localparam int BB   = 96;
    localparam int LB   = 6;
    localparam int BAUD = 16;
    localparam int TXN  = (BB / 8) * 10 * BAUD;

    typedef struct {
        logic [BB-1:0] q;
        logic          ok;
        logic          le;
    } blk_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_latch;
    logic [7:0]    frame_word;
    logic          s0;
    logic          s1;
    logic          txo0, bv0, ok0, le0, busy0;
    logic          txo1, bv1, ok1, le1, busy1;
    logic [BB-1:0] qbits0, qbits1;
    logic [7:0]    ovr0, ovr1;

    int n_cmp = 0;
    int n_bad = 0;

    blk_t       blk_q[$];
    logic [7:0] byte_q[$];
    bit         mon_dis = 1'b0;

    // Reference model of the capture path
    logic [BB-1:0] m_shift;
    int            m_cnt;
    logic [15:0]   m_crc;
    int            m_ovr0, m_ovr1;

    int busy0_cnt = 0, busy1_cnt = 0, low0_cnt = 0, low1_cnt = 0;

    subcode_rx_tx #(.LISTEN_BIT(LB), .BLOCK_BITS(BB), .BAUD_DIV(BAUD), .TX_MODE(0)) u_dut0 (
        .CLK50MHZ(clk), .rst(rst), .frameLatch(frame_latch), .frameWord(frame_word),
        .S0(s0), .S1(s1), .TxO(txo0), .qBits(qbits0), .blockValid(bv0), .crcOk(ok0),
        .lenErr(le0), .txBusy(busy0), .overrunCnt(ovr0)
    );

    subcode_rx_tx #(.LISTEN_BIT(LB), .BLOCK_BITS(BB), .BAUD_DIV(BAUD), .TX_MODE(1)) u_dut1 (
        .CLK50MHZ(clk), .rst(rst), .frameLatch(frame_latch), .frameWord(frame_word),
        .S0(s0), .S1(s1), .TxO(txo1), .qBits(qbits1), .blockValid(bv1), .crcOk(ok1),
        .lenErr(le1), .txBusy(busy1), .overrunCnt(ovr1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    // Activity counters used to check quiet lines and busy duration
    always @(negedge clk) begin
        if (busy0 === 1'b1) busy0_cnt++;
        if (busy1 === 1'b1) busy1_cnt++;
        if (txo0 === 1'b0) low0_cnt++;
        if (txo1 === 1'b0) low1_cnt++;
    end

    // Block monitor: every blockValid pulse consumes one expected block
    always @(negedge clk) begin
        if (bv0 === 1'b1) begin
            if (blk_q.size() == 0) begin
                check("bv_unexpected", bv0, 1'b0);
            end else begin
                blk_t e;
                e = blk_q.pop_front();
                check("qbits0", qbits0, e.q);
                check("crcok0", ok0, e.ok);
                check("lenerr0", le0, e.le);
                check("bv1", bv1, 1'b1);
                check("qbits1", qbits1, e.q);
                check("crcok1", ok1, e.ok);
                check("lenerr1", le1, e.le);
            end
        end
    end

    // UART monitor on the transmit-all instance: mid-bit sampling of 8N1 frames
    always begin
        @(negedge clk);
        if (!mon_dis && rst === 1'b0 && txo0 === 1'b0) begin
            logic [7:0] d;
            repeat (BAUD / 2 - 1) @(negedge clk);
            check("uart_start", txo0, 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                d[i] = txo0;
            end
            repeat (BAUD) @(negedge clk);
            check("uart_stop", txo0, 1'b1);
            if (byte_q.size() == 0) begin
                check("uart_unexpected", 1'b0, 1'b1);
            end else begin
                check("uart_byte", d, byte_q.pop_front());
            end
        end
    end

    task automatic model_clear();
        m_shift = '0;
        m_cnt   = 0;
        m_crc   = '0;
    endtask

    task automatic send_frame(input logic b, input logic s1_hold);
        logic [7:0] fw;
        fw         = 8'($urandom_range(0, 255));
        fw[LB]     = b;
        frame_word = fw;
        s1         = s1_hold;
        @(negedge clk);
        frame_latch = 1'b1;
        repeat (4) @(negedge clk);
        frame_latch = 1'b0;
        repeat (4) @(negedge clk);
        s1 = 1'b0;
        if (!s1_hold) begin
            if (m_cnt < BB - 16) m_crc = crc_step(m_crc, b);
            m_shift = {m_shift[BB-2:0], b};
            if (m_cnt < BB + 1) m_cnt++;
        end
    endtask

    // Data bits followed by the inverted CRC; flip corrupts the final bit
    task automatic send_block(input logic [BB-17:0] data, input bit flip);
        logic [15:0] c;
        logic        b;
        for (int i = BB - 17; i >= 0; i--) send_frame(data[i], 1'b0);
        c = m_crc;
        for (int i = 15; i >= 0; i--) begin
            b = ~c[i];
            if (i == 0 && flip) b = ~b;
            send_frame(b, 1'b0);
        end
    endtask

    task automatic end_block(input bit was_busy0, input bit was_busy1);
        blk_t e;
        bit   q0, q1, seen;
        e.le = (m_cnt != BB);
        e.ok = !e.le && (m_shift[15:0] == ~m_crc);
        e.q  = m_shift;
        blk_q.push_back(e);
        q0 = !e.le;
        q1 = !e.le && e.ok;
        if (q0 && !was_busy0 && !mon_dis) begin
            for (int i = 0; i < BB / 8; i++) byte_q.push_back(e.q[BB-1-8*i -: 8]);
        end
        if (q0 && was_busy0 && m_ovr0 < 255) m_ovr0++;
        if (q1 && was_busy1 && m_ovr1 < 255) m_ovr1++;
        s0   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = (blk_q.size() == 0);
        end
        check("blk_timeout", 32'(blk_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        s0 = 1'b0;
        repeat (6) @(negedge clk);
        check("ovr0", ovr0, 8'(m_ovr0));
        check("ovr1", ovr1, 8'(m_ovr1));
        model_clear();
    endtask

    task automatic wait_tx_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < TXN + 500 && !done; i++) begin
            @(negedge clk);
            done = (busy0 === 1'b0) && (busy1 === 1'b0);
        end
        check("tx_idle_timeout", {busy0, busy1}, 2'b00);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int            b0, b1, l0, l1;
        logic [BB-17:0] dat;
        logic [BB-1:0]  raw;

        rst         = 1'b1;
        frame_latch = 1'b0;
        frame_word  = '0;
        s0          = 1'b0;
        s1          = 1'b0;
        m_ovr0      = 0;
        m_ovr1      = 0;
        model_clear();
        repeat (5) @(negedge clk);
        check("rst_txo0", txo0, 1'b1);
        check("rst_qbits0", qbits0, '0);
        check("rst_bv0", bv0, 1'b0);
        check("rst_crcok0", ok0, 1'b0);
        check("rst_lenerr0", le0, 1'b0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_ovr0", ovr0, 8'h00);
        check("rst_txo1", txo1, 1'b1);
        rst = 1'b0;

        // Idle inputs: the line must stay quiet
        l0 = low0_cnt;
        b0 = busy0_cnt;
        repeat (10000) @(negedge clk);
        check("idle_txo_low", low0_cnt - l0, 0);
        check("idle_busy", busy0_cnt - b0, 0);

        // Block A: 80 zeros + 0xFFFF, good CRC; both instances transmit
        send_block('0, 1'b0);
        b0 = busy0_cnt;
        b1 = busy1_cnt;
        end_block(1'b0, 1'b0);
        check("A_qbits", qbits0, {80'h0, 16'hFFFF});
        check("A_crcok", ok0, 1'b1);
        wait_tx_idle();
        check("A_busy0_len", busy0_cnt - b0, TXN);
        check("A_busy1_len", busy1_cnt - b1, TXN);

        // Block B: bad CRC; only the transmit-all instance sends
        dat = {$urandom, $urandom, $urandom};
        send_block(dat, 1'b1);
        l1 = low1_cnt;
        b0 = busy0_cnt;
        end_block(1'b0, 1'b0);
        check("B_crcok", ok0, 1'b0);
        wait_tx_idle();
        check("B_txo1_quiet", low1_cnt - l1, 0);
        check("B_busy0_len", busy0_cnt - b0, TXN);

        // Block C: short block, never transmitted
        for (int i = 0; i < BB - 16; i++) send_frame(1'($urandom_range(0, 1)), 1'b0);
        b0 = busy0_cnt;
        end_block(1'b0, 1'b0);
        repeat (200) @(negedge clk);
        check("C_lenerr", le0, 1'b1);
        check("C_no_tx", busy0_cnt - b0, 0);

        // Empty block
        end_block(1'b0, 1'b0);
        check("Z_crcok", ok0, 1'b0);

        // Overrun: block E closes while block D is still being sent
        dat = {$urandom, $urandom, $urandom};
        send_block(dat, 1'b0);
        end_block(1'b0, 1'b0);
        dat = {$urandom, $urandom, $urandom};
        send_block(dat, 1'b0);
        check("E_still_busy", busy0, 1'b1);
        end_block(1'b1, 1'b1);
        wait_tx_idle();

        // S1 held high for three frames: 93 bits captured
        raw = {$urandom, $urandom, $urandom};
        for (int i = 0; i < BB; i++) send_frame(raw[BB-1-i], (i >= 40 && i < 43));
        end_block(1'b0, 1'b0);
        check("S1_lenerr", le0, 1'b1);

        // Over-long block: count saturates, still a length error
        dat = {$urandom, $urandom, $urandom};
        send_block(dat, 1'b0);
        send_frame(1'b1, 1'b0);
        send_frame(1'b0, 1'b0);
        b0 = busy0_cnt;
        end_block(1'b0, 1'b0);
        repeat (50) @(negedge clk);
        check("L_no_tx", busy0_cnt - b0, 0);

        // Reset in the middle of a byte
        mon_dis = 1'b1;
        dat = {$urandom, $urandom, $urandom};
        send_block(dat, 1'b0);
        end_block(1'b0, 1'b0);
        repeat (BAUD * 25) @(negedge clk);
        check("R_busy_before", busy0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("R_txo0", txo0, 1'b1);
        check("R_busy0", busy0, 1'b0);
        check("R_txo1", txo1, 1'b1);
        check("R_busy1", busy1, 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        m_ovr0 = 0;
        m_ovr1 = 0;
        check("R_ovr0", ovr0, 8'h00);
        check("R_qbits0", qbits0, '0);
        l0 = low0_cnt;
        repeat (500) @(negedge clk);
        check("R_quiet", low0_cnt - l0, 0);
        mon_dis = 1'b0;

        check("left_bytes", 32'(byte_q.size()), 32'd0);
        check("left_blocks", 32'(blk_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/subcode_rx_tx.md
Name: subcode_rx_tx

Overview:
Parametrised successor to the Q-channel subcode capture/transmit block. It extracts one selectable subcode channel bit (P..W) from each frame's control byte and assembles a block of BLOCK_BITS bits between sync marks. It checks the block's trailing CRC-16 and reports length and CRC status. It then serialises the block over an on-board 8N1 UART, either for every block or for CRC-good blocks only.

Parameters:
LISTEN_BIT, 6, bit of frameWord captured per frame (6 = Q channel).
BLOCK_BITS, 96, bits per subcode block; multiple of 8, ≥24; last 16 bits are the inverted CRC.
BAUD_DIV, 434, CLK50MHZ cycles per UART bit (115200 baud).
TX_MODE, 0, 0 = transmit every complete block; 1 = transmit only blocks with crcOk=1.

Ports:
CLK50MHZ  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
frameLatch  in  1  asynchronous frame strobe; rising edge marks a new frameWord.
frameWord  in  8  subcode control byte; stable ≥4 clocks after frameLatch rises.
S0  in  1  asynchronous sync flag; rising edge ends the current block.
S1  in  1  asynchronous sync flag; a high level blocks bit capture.
TxO  out  1  UART serial output, idle high.
qBits  out  BLOCK_BITS  last completed block; first-received bit in MSB.
blockValid  out  1  one-cycle pulse when qBits/crcOk/lenErr update.
crcOk  out  1  CRC status of the last completed block.
lenErr  out  1  last block bit count != BLOCK_BITS.
txBusy  out  1  UART transmitting.
overrunCnt  out  8  count of blocks dropped because UART busy; saturates at 255.

Behaviour:
- frameLatch, S0, S1: each passes a 2-FF synchroniser plus an edge register. Edge detect asserts 3 cycles after the input edge.
- Capture: on a frameLatch rising edge with synced S0=0 and S1=0:
  - shift frameWord[LISTEN_BIT] into the shift register at the LSB;
  - increment bitCnt, saturating at BLOCK_BITS+1;
  - while bitCnt < BLOCK_BITS-16, clock the bit into CRC-16 (poly 0x1021, init 0x0000, MSB-first).
- frameLatch edges with S0 or S1 high are ignored.
- Block end, on an S0 rising edge:
  - qBits <= shift register;
  - lenErr <= (bitCnt != BLOCK_BITS);
  - crcOk <= !lenErr_next && (shift[15:0] == ~crc);
  - blockValid pulses on the following cycle;
  - bitCnt, crc, and shift register clear.
- An S0 edge with bitCnt=0 still completes a block: lenErr=1, crcOk=0.
- Simultaneous frameLatch edge and S0 edge in the same cycle: block end wins; the frame bit is discarded.
- Transmit start, in the blockValid cycle: if txBusy=0, lenErr=0, and (TX_MODE=0 or crcOk=1), copy qBits to txBuf and start the UART.
  - If the block qualifies but txBusy=1: block is not sent; overrunCnt increments (saturating).
  - Non-qualifying blocks never count as overruns.
- UART FSM states: IDLE, START, DATA, STOP.
  - Sends BLOCK_BITS/8 bytes, txBuf[BLOCK_BITS-1:BLOCK_BITS-8] first.
  - Each byte: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly BAUD_DIV clocks.
  - Bytes go back to back with no inter-byte gap.
  - txBusy is high from the cycle after start until the last stop bit completes.
  - Total time: (BLOCK_BITS/8)·10·BAUD_DIV clocks.
- qBits may update during transmission; txBuf is unaffected.
- Reset values: TxO=1, qBits=0, blockValid=0, crcOk=0, lenErr=0, txBusy=0, overrunCnt=0. Internal shift register, bitCnt, crc, synchronisers, and FSM return to IDLE/zero.
- rst mid-transmission: TxO=1 on the cycle after rst is sampled; the partial byte is abandoned.

Test Plan:
- Reset → TxO=1, all status 0; no TxO activity for 10k cycles with inputs idle.
- Defaults, 80 zero data bits + 0xFFFF, then S0 edge → qBits=96'h0000…FFFF, crcOk=1, lenErr=0. TxO carries 10 bytes 0x00 then 0xFF,0xFF; bit period 434 clocks; txBusy high for 52080 clocks.
- Same block with last bit flipped (0xFFFE), TX_MODE=1 → crcOk=0, blockValid pulses, TxO stays high, overrunCnt=0. With TX_MODE=0 the block transmits.
- 80 bits then S0 edge → lenErr=1, crcOk=0, no transmission.
- Second valid block completes 10000 clocks into transmission → overrunCnt=1, qBits updates, transmitted bytes still those of the first block.
- S1 held high for 3 frameLatch edges mid-block → those bits not captured (block ends with 93 bits, lenErr=1). rst asserted mid-byte → TxO=1 next cycle, txBusy=0.
